// File: rtl/slave_rdresp2axi.sv
// ============================================================================
// Module   : slave_rdresp2axi
// Purpose  : Buffers memory read beats and re-forms them into AXI R bursts.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif

module slave_rdresp2axi #(
    parameter int AXI_SLAVE_ID = 0,
    parameter int DATA_W       = `WORD_SIZE,
    parameter int ID_W         = 8,
    parameter int LEN_W        = `AXI_LEN_WIDTH,
    parameter int DATA_DEPTH   = 16,
    parameter int CMD_DEPTH    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_push,
    input  logic [ID_W-1:0]   cmd_id,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              cmd_full,
    input  logic              mem2slave_rdresp_vld,
    input  logic [DATA_W-1:0] mem2slave_rdresp_data,
    output logic              rdresp_data_ready,
    output logic              rvalid,
    input  logic              rready,
    output logic [DATA_W-1:0] rdata,
    output logic [ID_W-1:0]   rid,
    output logic              rlast,
    output logic [1:0]        rresp,
    output logic              err
);

    localparam int              C_DA_W      = $clog2(DATA_DEPTH);
    localparam int              C_CA_W      = $clog2(CMD_DEPTH);
    localparam logic [C_DA_W:0] C_DATA_FULL = (C_DA_W+1)'(DATA_DEPTH);
    localparam logic [C_DA_W:0] C_DATA_TWO  = (C_DA_W+1)'(2);
    localparam logic [C_CA_W:0] C_CMD_FULL  = (C_CA_W+1)'(CMD_DEPTH);

    logic [DATA_W-1:0] r_dmem [DATA_DEPTH];
    logic [C_DA_W-1:0] r_dwr;
    logic [C_DA_W-1:0] r_drd;
    logic [C_DA_W:0]   r_dcnt;

    logic [ID_W-1:0]   r_cid  [CMD_DEPTH];
    logic [LEN_W-1:0]  r_clen [CMD_DEPTH];
    logic [C_CA_W-1:0] r_cwr;
    logic [C_CA_W-1:0] r_crd;
    logic [C_CA_W:0]   r_ccnt;

    logic [LEN_W-1:0]  r_beat_cnt;
    logic              r_rvalid;
    logic [DATA_W-1:0] r_rdata;
    logic [ID_W-1:0]   r_rid;
    logic              r_rlast;
    logic              r_err;

    logic w_dempty, w_dfull, w_dpush, w_dpop, w_derr;
    logic w_cempty, w_cfull, w_cpush, w_cpop, w_cerr;
    logic w_load, w_last, w_orphan;

    assign w_dempty = (r_dcnt == '0);
    assign w_dfull  = (r_dcnt == C_DATA_FULL);
    assign w_cempty = (r_ccnt == '0);
    assign w_cfull  = (r_ccnt == C_CMD_FULL);

    // Heads are only read when non-empty, so a same-cycle push never falls through.
    assign w_load   = (!r_rvalid || rready) && !w_dempty && !w_cempty;
    assign w_last   = (r_beat_cnt == r_clen[r_crd]);
    assign w_dpop   = w_load;
    assign w_cpop   = w_load && w_last;
    assign w_dpush  = mem2slave_rdresp_vld && (!w_dfull || w_dpop);
    assign w_cpush  = cmd_push && (!w_cfull || w_cpop);
    assign w_derr   = mem2slave_rdresp_vld && w_dfull && !w_dpop;
    assign w_cerr   = cmd_push && w_cfull && !w_cpop;
    assign w_orphan = !w_dempty && w_cempty;

    always_ff @(posedge clk) begin
        if (w_dpush) begin
            r_dmem[r_dwr] <= mem2slave_rdresp_data;
        end
        if (w_cpush) begin
            r_cid[r_cwr]  <= cmd_id;
            r_clen[r_cwr] <= cmd_len;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dwr      <= '0;
            r_drd      <= '0;
            r_dcnt     <= '0;
            r_cwr      <= '0;
            r_crd      <= '0;
            r_ccnt     <= '0;
            r_beat_cnt <= '0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rid      <= '0;
            r_rlast    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_dpush) r_dwr <= r_dwr + C_DA_W'(1);
            if (w_dpop)  r_drd <= r_drd + C_DA_W'(1);
            if (w_dpush && !w_dpop)      r_dcnt <= r_dcnt + (C_DA_W+1)'(1);
            else if (!w_dpush && w_dpop) r_dcnt <= r_dcnt - (C_DA_W+1)'(1);

            if (w_cpush) r_cwr <= r_cwr + C_CA_W'(1);
            if (w_cpop)  r_crd <= r_crd + C_CA_W'(1);
            if (w_cpush && !w_cpop)      r_ccnt <= r_ccnt + (C_CA_W+1)'(1);
            else if (!w_cpush && w_cpop) r_ccnt <= r_ccnt - (C_CA_W+1)'(1);

            if (w_load) begin
                r_rvalid   <= 1'b1;
                r_rdata    <= r_dmem[r_drd];
                r_rid      <= r_cid[r_crd];
                r_rlast    <= w_last;
                r_beat_cnt <= w_last ? '0 : r_beat_cnt + LEN_W'(1);
            end else if (rready) begin
                r_rvalid <= 1'b0;
            end

            r_err <= r_err | w_derr | w_cerr | w_orphan;
        end
    end

    // Keeps one slot free for the beat already in flight from the memory queue.
    assign rdresp_data_ready = ((C_DATA_FULL - r_dcnt) >= C_DATA_TWO);
    assign cmd_full          = w_cfull;
    assign rvalid            = r_rvalid;
    assign rdata             = r_rdata;
    assign rid               = r_rid;
    assign rlast             = r_rlast;
    assign rresp             = 2'b00;
    assign err               = r_err;

endmodule

`default_nettype wire

// File: tb/tb_slave_rdresp2axi.sv
// ============================================================================
// Module   : tb_slave_rdresp2axi
// Purpose  : Scoreboard bench for the AXI read-response return stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_slave_rdresp2axi;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_push = 1'b0;
    logic [7:0]  cmd_id = '0;
    logic [7:0]  cmd_len = '0;
    logic        cmd_full;
    logic        vld = 1'b0;
    logic [31:0] vdata = '0;
    logic        rdresp_data_ready;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [31:0] rdata;
    logic [7:0]  rid;
    logic        rlast;
    logic [1:0]  rresp;
    logic        err;

    slave_rdresp2axi #(
        .AXI_SLAVE_ID (0),
        .DATA_W       (32),
        .ID_W         (8),
        .LEN_W        (8),
        .DATA_DEPTH   (16),
        .CMD_DEPTH    (8)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .cmd_push              (cmd_push),
        .cmd_id                (cmd_id),
        .cmd_len               (cmd_len),
        .cmd_full              (cmd_full),
        .mem2slave_rdresp_vld  (vld),
        .mem2slave_rdresp_data (vdata),
        .rdresp_data_ready     (rdresp_data_ready),
        .rvalid                (rvalid),
        .rready                (rready),
        .rdata                 (rdata),
        .rid                   (rid),
        .rlast                 (rlast),
        .rresp                 (rresp),
        .err                   (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] d;
        logic [7:0]  id;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    bit   rnd_rdy = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) rready = 1'($urandom_range(0, 1));
    endtask

    // Monitor: pops the scoreboard on every handshake, checks stability on stalls.
    bit          stall = 1'b0;
    logic [31:0] sd;
    logic [7:0]  sid;
    logic        sl;
    always @(negedge clk) begin
        if (reset) begin
            stall = 1'b0;
        end else begin
            if (stall)
                chk("hold", {rvalid, rdata, rid, rlast}, {1'b1, sd, sid, sl});
            if (rvalid && rready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got data %0h id %0h, required none", rdata, rid);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rdata", rdata, e.d);
                    chk("rid", rid, e.id);
                    chk("rlast", rlast, e.last);
                    chk("rresp", rresp, 0);
                    if (e.cyc >= 0) chk("latency_cycle", cyc, e.cyc);
                end
            end
            stall = rvalid && !rready;
            sd = rdata;
            sid = rid;
            sl = rlast;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q.delete();
    endtask

    task automatic push_cmd(input logic [7:0] id, input logic [7:0] len);
        int n = 0;
        while (cmd_full && n < 200) begin tick(); n++; end
        if (n >= 200) chk("cmd_wait_timeout", 1, 0);
        cmd_push = 1'b1; cmd_id = id; cmd_len = len;
        tick();
        cmd_push = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [7:0] id,
                             input logic last, input bit timed, input bit expect_out);
        int n = 0;
        exp_t e;
        while (!rdresp_data_ready && n < 200) begin tick(); n++; end
        if (n >= 200) chk("ready_wait_timeout", 1, 0);
        e.d = d; e.id = id; e.last = last; e.cyc = timed ? cyc + 2 : -1;
        if (expect_out) q.push_back(e);
        vld = 1'b1; vdata = d;
        tick();
        vld = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 400) begin tick(); n++; end
        chk("drain_remaining", q.size(), 0);
    endtask

    initial begin
        tick(); tick();
        reset = 1'b0;
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_rid", rid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_err", err, 0);
        chk("rst_cmd_full", cmd_full, 0);
        chk("rst_ready", rdresp_data_ready, 1);

        // Single burst, back-to-back beats, fixed latency.
        push_cmd(8'h03, 8'd3);
        send_beat(32'hD000_0000, 8'h03, 1'b0, 1'b1, 1'b1);
        send_beat(32'hD000_0001, 8'h03, 1'b0, 1'b1, 1'b1);
        send_beat(32'hD000_0002, 8'h03, 1'b0, 1'b1, 1'b1);
        send_beat(32'hD000_0003, 8'h03, 1'b1, 1'b1, 1'b1);
        drain();
        tick();
        chk("single_rvalid_idle", rvalid, 0);
        chk("single_cmd_full", cmd_full, 0);

        // Interleaved commands.
        push_cmd(8'h01, 8'd0);
        push_cmd(8'h02, 8'd1);
        push_cmd(8'h03, 8'd0);
        send_beat(32'h11, 8'h01, 1'b1, 1'b0, 1'b1);
        send_beat(32'h22, 8'h02, 1'b0, 1'b0, 1'b1);
        send_beat(32'h33, 8'h02, 1'b1, 1'b0, 1'b1);
        send_beat(32'h44, 8'h03, 1'b1, 1'b0, 1'b1);
        drain();

        // Backpressure: 16-beat burst with rready low.
        rready = 1'b0;
        push_cmd(8'h07, 8'd15);
        for (int i = 0; i < 16; i++)
            send_beat(32'hB000_0000 + i, 8'h07, (i == 15), 1'b0, 1'b1);
        tick();
        chk("bp_ready_low", rdresp_data_ready, 0);
        chk("bp_err", err, 0);
        chk("bp_rvalid", rvalid, 1);
        repeat (3) tick();
        rready = 1'b1;
        drain();
        chk("bp_ready_back", rdresp_data_ready, 1);

        // Wrap-around with random rready.
        rnd_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int n = 0;
            exp_t e;
            while ((cmd_full || !rdresp_data_ready) && n < 200) begin tick(); n++; end
            if (n >= 200) chk("wrap_wait_timeout", 1, 0);
            e.d = 32'hA000_0000 + i; e.id = 8'(i + 8'h40); e.last = 1'b1; e.cyc = -1;
            q.push_back(e);
            cmd_push = 1'b1; cmd_id = e.id; cmd_len = 8'd0;
            vld = 1'b1; vdata = e.d;
            tick();
            cmd_push = 1'b0; vld = 1'b0;
        end
        drain();
        rnd_rdy = 1'b0;
        rready = 1'b1;
        tick();
        chk("wrap_err", err, 0);

        // Beat with no command queued.
        send_beat(32'hEEEE_0001, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        chk("orphan_err", err, 1);
        chk("orphan_rvalid", rvalid, 0);
        do_reset();
        chk("orphan_reset_err", err, 0);

        // Command FIFO overflow.
        for (int i = 0; i < 8; i++) push_cmd(8'(i), 8'd0);
        chk("cmd_full_set", cmd_full, 1);
        chk("cmd_full_no_err", err, 0);
        cmd_push = 1'b1; cmd_id = 8'h99; cmd_len = 8'd0;
        tick();
        cmd_push = 1'b0;
        tick();
        chk("cmd_overflow_err", err, 1);
        do_reset();
        chk("reset_cmd_full", cmd_full, 0);

        // Reset in the middle of a burst.
        rready = 1'b0;
        push_cmd(8'h05, 8'd3);
        send_beat(32'hC000_0000, 8'h05, 1'b0, 1'b0, 1'b0);
        send_beat(32'hC000_0001, 8'h05, 1'b0, 1'b0, 1'b0);
        tick();
        do_reset();
        chk("midrst_rvalid", rvalid, 0);
        chk("midrst_ready", rdresp_data_ready, 1);
        chk("midrst_err", err, 0);
        rready = 1'b1;
        push_cmd(8'h06, 8'd1);
        send_beat(32'hF000_0000, 8'h06, 1'b0, 1'b1, 1'b1);
        send_beat(32'hF000_0001, 8'h06, 1'b1, 1'b1, 1'b1);
        drain();
        tick();
        chk("final_err", err, 0);
        chk("final_rvalid", rvalid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
